// File: rtl/valve_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : valve_seq_pkg
// Purpose  : Shared types and constants for the valve sequencer: FSM state
//            encoding, command-entry layout {valve, open} and grant pointer
//            encodings.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package valve_seq_pkg;

  // Sequencer FSM states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_APPLY  = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  // Command entry layout: {valve, open}; open sits in bit 0
  localparam int CMD_OPEN_LSB  = 0;
  localparam int CMD_VALVE_LSB = 1;

  // Round-robin grant pointer encodings
  localparam logic GRANT_MAN  = 1'b0;
  localparam logic GRANT_PROG = 1'b1;

  // Width of one queued command for a given valve index width
  function automatic int cmd_width(input int valve_w);
    return valve_w + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/valve_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module   : valve_cmd_fifo
// Purpose  : Small synchronous command FIFO (power-of-2 depth) with a
//            synchronous flush. Head entry is presented combinationally
//            from registered storage.
// Ports    : clk, rst (async active-low), flush, push/push_data,
//            pop/pop_data, full, empty
// Revision : 1.0 - initial release
// ============================================================================
module valve_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  // Pointers carry one extra wrap bit to tell full from empty
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push  = push && !full && !flush;
  assign do_pop   = pop && !empty && !flush;
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/valve_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : valve_sequencer
// Purpose  : Round-robin arbitration of program and manual valve commands
//            into a small FIFO, then applies them one at a time, holding a
//            settle interval after each real valve move so only one servo
//            slews at once. Drives persistent per-valve set_bit levels.
// Ports    : clk, rst (async active-low)
//            prog_valid/prog_valve/prog_open/prog_ready - program requester
//            man_valid/man_valve/man_open/man_ready     - manual requester
//            flush       - discard queue and abort settle
//            valve_state - per-valve level to servo interfaces
//            cmd_done/done_valve - completion pulse and its valve index
//            busy        - FSM active or queue non-empty
// Revision : 1.0 - initial release
// ============================================================================
module valve_sequencer
  import valve_seq_pkg::*;
#(
  parameter int NUM_VALVES    = 4,
  parameter int VALVE_W       = 2,
  parameter int SETTLE_CYCLES = 50000000,
  parameter int CNT_W         = 26,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  prog_valid,
  input  logic [VALVE_W-1:0]    prog_valve,
  input  logic                  prog_open,
  output logic                  prog_ready,
  input  logic                  man_valid,
  input  logic [VALVE_W-1:0]    man_valve,
  input  logic                  man_open,
  output logic                  man_ready,
  input  logic                  flush,
  output logic [NUM_VALVES-1:0] valve_state,
  output logic                  cmd_done,
  output logic [VALVE_W-1:0]    done_valve,
  output logic                  busy
);

  localparam int               CMD_W       = cmd_width(VALVE_W);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [VALVE_W-1:0] cmd_valve;
  logic               cmd_open;
  logic               grant_ptr;
  logic               ready_en;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CMD_W-1:0]   head;
  logic               accept_ok;
  logic               man_fire;
  logic               prog_fire;
  logic               push;
  logic [CMD_W-1:0]   push_data;
  logic               pop;

  // ready_en is cleared asynchronously by reset, which keeps both readies
  // low for the whole time rst is asserted without routing rst into
  // combinational logic; it sets on the first edge after release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ready_en <= 1'b0;
    else      ready_en <= 1'b1;
  end

  // When both requesters are valid only the pointer's choice sees ready;
  // a lone requester sees ready whenever there is room.
  assign accept_ok  = ready_en && !flush && !fifo_full;
  assign prog_ready = accept_ok && (!man_valid  || (grant_ptr == GRANT_PROG));
  assign man_ready  = accept_ok && (!prog_valid || (grant_ptr == GRANT_MAN));
  assign man_fire   = man_valid  && man_ready;
  assign prog_fire  = prog_valid && prog_ready;
  assign push       = man_fire || prog_fire;
  assign push_data  = man_fire ? {man_valve, man_open} : {prog_valve, prog_open};

  // Pointer moves only on contested grants
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_ptr <= GRANT_MAN;
    end else if (man_valid && prog_valid && push) begin
      grant_ptr <= (grant_ptr == GRANT_MAN) ? GRANT_PROG : GRANT_MAN;
    end
  end

  assign pop = (state == ST_IDLE) && !fifo_empty;

  valve_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      cmd_valve   <= '0;
      cmd_open    <= 1'b0;
      valve_state <= '0;
      cmd_done    <= 1'b0;
      done_valve  <= '0;
    end else begin
      cmd_done <= 1'b0;
      if (flush) begin
        // Abort without completion; an already-applied level is kept
        state <= ST_IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (!fifo_empty) begin
              cmd_valve <= head[CMD_VALVE_LSB +: VALVE_W];
              cmd_open  <= head[CMD_OPEN_LSB];
              state     <= ST_APPLY;
            end
          end
          ST_APPLY: begin
            if (valve_state[cmd_valve] == cmd_open) begin
              // Already at the requested level: complete with no settle
              cmd_done   <= 1'b1;
              done_valve <= cmd_valve;
              state      <= ST_IDLE;
            end else begin
              valve_state[cmd_valve] <= cmd_open;
              cnt                    <= SETTLE_LOAD;
              state                  <= ST_SETTLE;
            end
          end
          ST_SETTLE: begin
            if (cnt == '0) begin
              cmd_done   <= 1'b1;
              done_valve <= cmd_valve;
              state      <= ST_IDLE;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign busy = (state != ST_IDLE) || !fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_valve_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_valve_sequencer
// Purpose  : Scoreboard bench for valve_sequencer with SETTLE_CYCLES=10,
//            FIFO_DEPTH=4. Issued commands push {valve, expected state}
//            into a queue; a monitor pops on every cmd_done.
// Revision : 1.0 - initial release
// ============================================================================
module tb_valve_sequencer;
  import valve_seq_pkg::*;

  typedef struct packed {
    logic [1:0] valve;
    logic [3:0] state;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       prog_valid = 1'b0;
  logic [1:0] prog_valve = '0;
  logic       prog_open = 1'b0;
  logic       prog_ready;
  logic       man_valid = 1'b0;
  logic [1:0] man_valve = '0;
  logic       man_open = 1'b0;
  logic       man_ready;
  logic       flush = 1'b0;
  logic [3:0] valve_state;
  logic       cmd_done;
  logic [1:0] done_valve;
  logic       busy;

  exp_t       sb[$];
  int         total = 0;
  int         bad = 0;
  logic [3:0] mdl = 4'b0000;
  logic       ptr_m = GRANT_MAN;

  always #5 clk = ~clk;

  valve_sequencer #(
    .NUM_VALVES    (4),
    .VALVE_W       (2),
    .SETTLE_CYCLES (10),
    .CNT_W         (8),
    .FIFO_DEPTH    (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .prog_valid  (prog_valid),
    .prog_valve  (prog_valve),
    .prog_open   (prog_open),
    .prog_ready  (prog_ready),
    .man_valid   (man_valid),
    .man_valve   (man_valve),
    .man_open    (man_open),
    .man_ready   (man_ready),
    .flush       (flush),
    .valve_state (valve_state),
    .cmd_done    (cmd_done),
    .done_valve  (done_valve),
    .busy        (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_cmd(input logic [1:0] v, input logic o);
    exp_t e;
    mdl[v]  = o;
    e.valve = v;
    e.state = mdl;
    sb.push_back(e);
  endtask

  task automatic wait_done(input int max, output int n);
    n = 0;
    while (!cmd_done && n < max) begin
      tick();
      n++;
    end
    if (!cmd_done) chk("done_timeout", {31'd0, cmd_done}, 32'd1);
  endtask

  task automatic quiet(input int cycles, input string name);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (cmd_done) seen++;
    end
    chk(name, seen, 0);
  endtask

  task automatic drive_prog(input logic [1:0] v, input logic o);
    prog_valid = 1'b1;
    prog_valve = v;
    prog_open  = o;
  endtask

  // Monitor: every completion must match the oldest outstanding expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (cmd_done) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got done_valve=%0d expected no completion", done_valve);
        end else begin
          e = sb.pop_front();
          chk("done_valve", done_valve, e.valve);
          chk("state_at_done", valve_state, e.state);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no end expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int mi;
    int pi;
    int cyc;
    logic m_fire;
    logic p_fire;
    logic [1:0] mv[4] = '{2'd0, 2'd3, 2'd1, 2'd2};
    logic       mo[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [1:0] pv[4] = '{2'd1, 2'd3, 2'd0, 2'd2};
    logic       po[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    // ---------------- reset ----------------
    prog_valid = 1'b1;
    man_valid  = 1'b1;
    repeat (3) tick();
    chk("rst_valve_state", valve_state, 4'b0000);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_done", cmd_done, 0);
    chk("rst_done_valve", done_valve, 0);
    chk("rst_readies", {man_ready, prog_ready}, 2'b00);
    prog_valid = 1'b0;
    man_valid  = 1'b0;
    rst = 1'b1;
    tick();
    tick();

    // ---------------- single move: prog {2,1} ----------------
    drive_prog(2'd2, 1'b1);
    #1;
    chk("t1_prog_ready", prog_ready, 1);
    expect_cmd(2'd2, 1'b1);
    tick();                                   // E0
    prog_valid = 1'b0;
    chk("t1_busy_after_accept", busy, 1);
    tick();                                   // E1
    chk("t1_state_before_apply", valve_state, 4'b0000);
    tick();                                   // E2
    chk("t1_state_after_apply", valve_state, 4'b0100);
    wait_done(30, n);
    chk("t1_settle_cycles", n, 10);
    tick();
    chk("t1_busy_after_done", busy, 0);

    // ---------------- no-op: prog {1,0} ----------------
    drive_prog(2'd1, 1'b0);
    #1;
    chk("t3_prog_ready", prog_ready, 1);
    expect_cmd(2'd1, 1'b0);
    tick();
    prog_valid = 1'b0;
    wait_done(30, n);
    chk("t3_noop_latency", n, 2);
    chk("t3_state_unchanged", valve_state, 4'b0100);
    tick();

    // ---------------- contested arbitration ----------------
    mi = 0;
    pi = 0;
    cyc = 0;
    while ((mi < 4 || pi < 4) && cyc < 300) begin
      man_valid  = (mi < 4);
      prog_valid = (pi < 4);
      if (mi < 4) begin man_valve = mv[mi]; man_open = mo[mi]; end
      if (pi < 4) begin prog_valve = pv[pi]; prog_open = po[pi]; end
      #1;
      if (cyc < 5)
        chk($sformatf("t2_grant_c%0d", cyc), {man_ready, prog_ready},
            (cyc % 2 == 0) ? 2'b10 : 2'b01);
      else if (cyc == 5)
        chk("t2_full_readies", {man_ready, prog_ready}, 2'b00);
      m_fire = man_valid && man_ready;
      p_fire = prog_valid && prog_ready;
      if (man_valid && prog_valid && (m_fire || p_fire)) begin
        chk("t2_rr_winner", {m_fire, p_fire}, (ptr_m == GRANT_MAN) ? 2'b10 : 2'b01);
        ptr_m = ~ptr_m;
      end
      if (m_fire) begin
        expect_cmd(mv[mi], mo[mi]);
        mi++;
      end else if (p_fire) begin
        expect_cmd(pv[pi], po[pi]);
        pi++;
      end
      tick();
      cyc++;
    end
    man_valid  = 1'b0;
    prog_valid = 1'b0;
    chk("t2_all_accepted", mi + pi, 8);
    cyc = 0;
    while (sb.size() > 0 && cyc < 400) begin
      tick();
      cyc++;
    end
    chk("t2_drained", sb.size(), 0);
    tick();
    chk("t2_final_state", valve_state, 4'b0110);

    // ---------------- flush mid-settle ----------------
    drive_prog(2'd0, 1'b1); #1; chk("t4_ready0", prog_ready, 1); expect_cmd(2'd0, 1'b1); tick();
    drive_prog(2'd3, 1'b1); #1; chk("t4_ready1", prog_ready, 1); expect_cmd(2'd3, 1'b1); tick();
    drive_prog(2'd1, 1'b0); #1; chk("t4_ready2", prog_ready, 1); expect_cmd(2'd1, 1'b0); tick();
    prog_valid = 1'b0;
    chk("t4_first_applied", valve_state, 4'b0111);
    repeat (3) tick();
    flush = 1'b1;
    #1;
    chk("t4_readies_in_flush", {man_ready, prog_ready}, 2'b00);
    tick();
    flush = 1'b0;
    sb.delete();
    mdl = 4'b0111;
    chk("t4_busy_after_flush", busy, 0);
    chk("t4_state_kept", valve_state, 4'b0111);
    quiet(15, "t4_no_done");

    // ---------------- reset mid-settle at 1011 ----------------
    drive_prog(2'd3, 1'b1); #1; chk("t5_ready_a", prog_ready, 1); expect_cmd(2'd3, 1'b1); tick();
    prog_valid = 1'b0;
    wait_done(30, n);
    tick();
    drive_prog(2'd2, 1'b0);
    #1;
    tick();                                   // E0 (not tracked: aborted)
    prog_valid = 1'b0;
    tick();
    tick();
    chk("t5_state_1011", valve_state, 4'b1011);
    tick();
    tick();
    rst = 1'b0;
    drive_prog(2'd1, 1'b1);
    man_valid = 1'b1;
    man_valve = 2'd0;
    man_open  = 1'b1;
    #1;
    chk("t5_rst_state", valve_state, 4'b0000);
    chk("t5_rst_readies", {man_ready, prog_ready}, 2'b00);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_done", cmd_done, 0);
    tick();
    chk("t5_rst_readies_edge", {man_ready, prog_ready}, 2'b00);
    man_valid = 1'b0;
    rst = 1'b1;
    mdl = 4'b0000;
    ptr_m = GRANT_MAN;
    tick();
    chk("t5_ready_after_release", prog_ready, 1);
    expect_cmd(2'd1, 1'b1);
    tick();
    prog_valid = 1'b0;
    wait_done(30, n);
    chk("t5_resume_settle", n, 12);
    tick();

    // ---------------- flush with same-cycle prog_valid ----------------
    flush = 1'b1;
    drive_prog(2'd2, 1'b1);
    #1;
    chk("t6_prog_ready", prog_ready, 0);
    tick();
    flush = 1'b0;
    prog_valid = 1'b0;
    chk("t6_busy", busy, 0);
    quiet(15, "t6_no_done");
    chk("t6_state", valve_state, 4'b0010);

    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
